// File: rtl/i2c_slave_responder.sv
// I2C target answering SLAVE_ADDR: oversampled START/STOP/bit decode, write-byte strobe, read serialiser.
// Optional build macro I2C_SLAVE_GLITCH_FILTER_EN adds a 3-sample stability filter on scl/sda.
`timescale 1ns/1ps
module i2c_slave_responder #(
  parameter logic [6:0]  SLAVE_ADDR  = 7'h42,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       scl,
  inout  wire        sda,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       busy,
  output logic       addr_hit
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WRITE, S_WRITE_ACK, S_READ, S_READ_ACK, S_IDLE_WAIT
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic scl_c, sda_c, scl_prev_q, sda_prev_q;

  // Synchronisers and edge history are not reset so a reset never fabricates a bus event.
  always_ff @(posedge CLOCK_50) begin
    scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl};
    sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda};
    scl_prev_q <= scl_c;
    sda_prev_q <= sda_c;
  end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  logic [1:0] scl_hist_q, sda_hist_q;
  logic       scl_filt_q, sda_filt_q;
  logic       scl_stable, sda_stable;

  assign scl_stable = (scl_hist_q == {2{scl_sync_q[SYNC_STAGES-1]}});
  assign sda_stable = (sda_hist_q == {2{sda_sync_q[SYNC_STAGES-1]}});
  assign scl_c = scl_stable ? scl_sync_q[SYNC_STAGES-1] : scl_filt_q;
  assign sda_c = sda_stable ? sda_sync_q[SYNC_STAGES-1] : sda_filt_q;

  always_ff @(posedge CLOCK_50) begin
    scl_hist_q <= {scl_hist_q[0], scl_sync_q[SYNC_STAGES-1]};
    sda_hist_q <= {sda_hist_q[0], sda_sync_q[SYNC_STAGES-1]};
    if (scl_stable) scl_filt_q <= scl_sync_q[SYNC_STAGES-1];
    if (sda_stable) sda_filt_q <= sda_sync_q[SYNC_STAGES-1];
  end
`else
  assign scl_c = scl_sync_q[SYNC_STAGES-1];
  assign sda_c = sda_sync_q[SYNC_STAGES-1];
`endif

  logic scl_rise, scl_fall, start_det, stop_det, addr_match;
  assign scl_rise   = scl_c & ~scl_prev_q;
  assign scl_fall   = ~scl_c & scl_prev_q;
  assign start_det  = scl_c & scl_prev_q & sda_prev_q & ~sda_c;
  assign stop_det   = scl_c & scl_prev_q & ~sda_prev_q & sda_c;

  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] shift_q, shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic rw_q, rw_d, sda_oe_q, sda_oe_d;
  logic rx_valid_q, rx_valid_d, tx_req_q, tx_req_d;
  logic busy_q, busy_d, addr_hit_q, addr_hit_d;

  assign addr_match = (shift_q == SLAVE_ADDR);

  always_ff @(posedge CLOCK_50) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (stop_det)       state_d = S_IDLE;
    else if (start_det) state_d = S_ADDR;
    else begin
      case (state_q)
        S_ADDR:      if (scl_rise && bit_cnt_q == 3'd7) state_d = addr_match ? S_ADDR_ACK : S_IDLE;
        S_ADDR_ACK:  if (scl_fall && sda_oe_q)          state_d = rw_q ? S_READ : S_WRITE;
        S_WRITE:     if (scl_rise && bit_cnt_q == 3'd7) state_d = S_WRITE_ACK;
        S_WRITE_ACK: if (scl_fall && sda_oe_q)          state_d = S_WRITE;
        S_READ:      if (scl_fall && bit_cnt_q == 3'd7) state_d = S_READ_ACK;
        S_READ_ACK: begin
          if (scl_rise && sda_c) state_d = S_IDLE_WAIT;
          else if (scl_fall)     state_d = S_READ;
        end
        default: state_d = state_q;
      endcase
    end
  end

  // ACK phases use sda_oe_q as the sub-phase: first falling edge drives low, second ends the ACK.
  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    rx_data_d  = rx_data_q;
    rw_d       = rw_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    rx_valid_d = 1'b0;
    tx_req_d   = 1'b0;
    addr_hit_d = 1'b0;
    if (stop_det) begin
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else if (start_det) begin
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
    end else begin
      case (state_q)
        S_ADDR, S_WRITE: begin
          if (scl_rise) begin
            shift_d   = {shift_q[5:0], sda_c};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (state_q == S_WRITE) begin
                rx_data_d  = {shift_q, sda_c};
                rx_valid_d = 1'b1;
              end else if (addr_match) begin
                rw_d       = sda_c;
                busy_d     = 1'b1;
                addr_hit_d = 1'b1;
              end else begin
                busy_d = 1'b0;
              end
            end
          end
        end
        S_ADDR_ACK, S_WRITE_ACK, S_READ_ACK: begin
          if (scl_fall) begin
            if (state_q != S_READ_ACK && !sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else if (state_q == S_READ_ACK || (state_q == S_ADDR_ACK && rw_q)) begin
              shift_d   = tx_data[6:0];
              sda_oe_d  = ~tx_data[7];
              tx_req_d  = 1'b1;
              bit_cnt_d = '0;
            end else begin
              sda_oe_d = 1'b0;
            end
          end
        end
        S_READ: begin
          if (scl_fall) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            sda_oe_d  = (bit_cnt_q == 3'd7) ? 1'b0 : ~shift_q[6];
            shift_d   = {shift_q[5:0], 1'b0};
          end
        end
        default: sda_oe_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      rx_data_q  <= '0;
      rw_q       <= 1'b0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      addr_hit_q <= 1'b0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      rw_q       <= rw_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      rx_valid_q <= rx_valid_d;
      tx_req_q   <= tx_req_d;
      addr_hit_q <= addr_hit_d;
    end
  end

  assign sda      = sda_oe_q ? 1'b0 : 1'bz;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign tx_req   = tx_req_q;
  assign busy     = busy_q;
  assign addr_hit = addr_hit_q;

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Directed bench for i2c_slave_responder acting as I2C master over an open-drain bus.
`timescale 1ns/1ps
module tb_i2c_slave_responder;

  localparam int Q = 160;  // quarter SCL period in ns

  logic       CLOCK_50, reset, scl_r, m_low;
  logic [7:0] tx_data, rx_data;
  logic       rx_valid, tx_req, busy, addr_hit;
  wire        sda;

  pullup (sda);
  assign sda = m_low ? 1'b0 : 1'bz;

  i2c_slave_responder #(.SLAVE_ADDR(7'h42), .SYNC_STAGES(2)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .scl(scl_r), .sda(sda),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data),
    .tx_req(tx_req), .busy(busy), .addr_hit(addr_hit)
  );

  int checks = 0, failures = 0;
  int rxv_cnt = 0, txr_cnt = 0, hit_cnt = 0;

  initial begin
    CLOCK_50 = 1'b0;
    forever #10 CLOCK_50 = ~CLOCK_50;
  end

  always @(posedge CLOCK_50) begin
    if (rx_valid) rxv_cnt++;
    if (tx_req)   txr_cnt++;
    if (addr_hit) hit_cnt++;
  end

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic bus_bit(input logic b, output logic r);
    m_low = ~b; #(Q);
    scl_r = 1'b1; #(Q);
    r = sda; #(Q);
    scl_r = 1'b0; #(Q);
  endtask

  task automatic bus_bit_glitch(input logic b, output logic r);
    m_low = ~b; #(Q);
    scl_r = 1'b1; #(Q/2);
    scl_r = 1'b0; #40;
    scl_r = 1'b1; #(Q/2 - 40);
    r = sda; #(Q);
    scl_r = 1'b0; #(Q);
  endtask

  task automatic bus_start();
    m_low = 1'b1; #(Q);
    scl_r = 1'b0; #(Q);
  endtask

  task automatic bus_rstart();
    m_low = 1'b0; #(Q);
    scl_r = 1'b1; #(Q);
    m_low = 1'b1; #(Q);
    scl_r = 1'b0; #(Q);
  endtask

  task automatic bus_stop();
    m_low = 1'b1; #(Q);
    scl_r = 1'b1; #(Q);
    m_low = 1'b0; #(2*Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bus_bit(d[i], r);
    bus_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic mack, input logic [7:0] next_tx, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, r);
      d[i] = r;
    end
    tx_data = next_tx;
    bus_bit(~mack, r);
  endtask

  task automatic test_reset();
    reset = 1'b1; scl_r = 1'b1; m_low = 1'b0; tx_data = 8'h00;
    repeat (5) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    reset = 1'b0;
    #(Q);
    checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL rst_rx_data: got %h want 00", rx_data); end
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL rst_rx_valid: got %b want 0", rx_valid); end
    checks++; if (tx_req !== 1'b0)   begin failures++; $display("FAIL rst_tx_req: got %b want 0", tx_req); end
    checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (addr_hit !== 1'b0) begin failures++; $display("FAIL rst_addr_hit: got %b want 0", addr_hit); end
    checks++; if (sda !== 1'b1)      begin failures++; $display("FAIL rst_sda: got %b want 1", sda); end
  endtask

  task automatic test_write();
    logic ack; int rxv0, hit0;
    rxv0 = rxv_cnt; hit0 = hit_cnt;
    bus_start();
    write_byte(8'h84, ack);
    checks++; if (ack !== 1'b0) begin failures++; $display("FAIL wr_addr_ack: got %b want 0", ack); end
    checks++; if (hit_cnt - hit0 != 1) begin failures++; $display("FAIL wr_addr_hit: got %0d want 1", hit_cnt - hit0); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL wr_busy: got %b want 1", busy); end
    write_byte(8'hA5, ack);
    checks++; if (ack !== 1'b0) begin failures++; $display("FAIL wr_data_ack: got %b want 0", ack); end
    bus_stop();
    checks++; if (rx_data !== 8'hA5) begin failures++; $display("FAIL wr_rx_data: got %h want a5", rx_data); end
    checks++; if (rxv_cnt - rxv0 != 1) begin failures++; $display("FAIL wr_rx_valid: got %0d want 1", rxv_cnt - rxv0); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL wr_busy_stop: got %b want 0", busy); end
  endtask

  task automatic test_addr_mismatch();
    logic ack; int rxv0, hit0;
    rxv0 = rxv_cnt; hit0 = hit_cnt;
    bus_start();
    write_byte(8'h86, ack);
    checks++; if (ack !== 1'b1) begin failures++; $display("FAIL nm_addr_ack: got %b want 1", ack); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL nm_busy: got %b want 0", busy); end
    write_byte(8'h77, ack);
    checks++; if (ack !== 1'b1) begin failures++; $display("FAIL nm_data_ack: got %b want 1", ack); end
    bus_stop();
    checks++; if (hit_cnt != hit0) begin failures++; $display("FAIL nm_addr_hit: got %0d want 0", hit_cnt - hit0); end
    checks++; if (rxv_cnt != rxv0) begin failures++; $display("FAIL nm_rx_valid: got %0d want 0", rxv_cnt - rxv0); end
  endtask

  task automatic test_read();
    logic ack; logic [7:0] d; int txr0;
    txr0 = txr_cnt;
    tx_data = 8'h3C;
    bus_start();
    write_byte(8'h85, ack);
    checks++; if (ack !== 1'b0) begin failures++; $display("FAIL rd_addr_ack: got %b want 0", ack); end
    read_byte(1'b1, 8'hF0, d);
    checks++; if (d !== 8'h3C) begin failures++; $display("FAIL rd_byte0: got %h want 3c", d); end
    read_byte(1'b0, 8'h00, d);
    checks++; if (d !== 8'hF0) begin failures++; $display("FAIL rd_byte1: got %h want f0", d); end
    checks++; if (sda !== 1'b1) begin failures++; $display("FAIL rd_nack_release: got %b want 1", sda); end
    checks++; if (txr_cnt - txr0 != 2) begin failures++; $display("FAIL rd_tx_req: got %0d want 2", txr_cnt - txr0); end
    bus_stop();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rd_busy_stop: got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    logic ack; logic [7:0] d;
    bus_start();
    write_byte(8'h84, ack);
    write_byte(8'h11, ack);
    checks++; if (ack !== 1'b0) begin failures++; $display("FAIL rs_data_ack: got %b want 0", ack); end
    tx_data = 8'h99;
    bus_rstart();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rs_busy_rstart: got %b want 1", busy); end
    write_byte(8'h85, ack);
    checks++; if (ack !== 1'b0) begin failures++; $display("FAIL rs_addr_ack: got %b want 0", ack); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rs_busy_read: got %b want 1", busy); end
    read_byte(1'b0, 8'h00, d);
    checks++; if (d !== 8'h99) begin failures++; $display("FAIL rs_read: got %h want 99", d); end
    bus_stop();
    checks++; if (rx_data !== 8'h11) begin failures++; $display("FAIL rs_rx_data: got %h want 11", rx_data); end
  endtask

  task automatic test_reset_mid_ack();
    logic ack, r;
    bus_start();
    for (int i = 7; i >= 0; i--) bus_bit(((8'h84 >> i) & 8'h01) != 8'h00, r);
    m_low = 1'b0; #(Q);
    scl_r = 1'b1; #(Q/2);
    checks++; if (sda !== 1'b0) begin failures++; $display("FAIL rm_ack_driven: got %b want 0", sda); end
    reset = 1'b1; #20;
    checks++; if (sda !== 1'b1) begin failures++; $display("FAIL rm_sda_release: got %b want 1", sda); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rm_busy: got %b want 0", busy); end
    checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL rm_rx_data: got %h want 00", rx_data); end
    #40; reset = 1'b0; #(Q);
    scl_r = 1'b0; #(Q);
    bus_rstart();
    write_byte(8'h84, ack);
    checks++; if (ack !== 1'b0) begin failures++; $display("FAIL rm_addr_ack: got %b want 0", ack); end
    write_byte(8'h5A, ack);
    bus_stop();
    checks++; if (rx_data !== 8'h5A) begin failures++; $display("FAIL rm_rx_data_after: got %h want 5a", rx_data); end
  endtask

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  task automatic test_glitch_filter();
    logic ack, r; int rxv0;
    logic [7:0] d;
    d = 8'hA5;
    rxv0 = rxv_cnt;
    bus_start();
    write_byte(8'h84, ack);
    for (int i = 7; i >= 0; i--) begin
      if (i == 4) bus_bit_glitch(d[i], r);
      else        bus_bit(d[i], r);
    end
    bus_bit(1'b1, ack);
    checks++; if (ack !== 1'b0) begin failures++; $display("FAIL gf_ack: got %b want 0", ack); end
    bus_stop();
    checks++; if (rx_data !== 8'hA5) begin failures++; $display("FAIL gf_rx_data: got %h want a5", rx_data); end
    checks++; if (rxv_cnt - rxv0 != 1) begin failures++; $display("FAIL gf_rx_valid: got %0d want 1", rxv_cnt - rxv0); end
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_addr_mismatch();
    test_read();
    test_back_to_back();
    test_reset_mid_ack();
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    test_glitch_filter();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_slave_responder.md
Name: i2c_slave_responder

Overview:
- I2C target (responder) for the team's existing I2C master. Sits on the same open-drain `sda`/`scl` pair and answers one 7-bit address.
- Oversamples SCL/SDA on CLOCK_50 and decodes START, STOP, address, R/W and data bytes.
- Write transfers: hands each received byte to user logic with a one-cycle strobe.
- Read transfers: serialises a user-supplied byte.
- Multi-byte transfers and repeated START are supported.

Parameters:
- SLAVE_ADDR, 7'h42, 7-bit address this block ACKs.
- SYNC_STAGES, 2, synchroniser flops on `scl` and `sda` inputs (min 2).

Ports:
- CLOCK_50  in  1  system clock, 50 MHz; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- scl  in  1  I2C clock from the master (this block never drives it).
- sda  inout  1  open-drain data; driven 0 or 'z' only, never driven 1.
- rx_data  out  8  last byte written by the master.
- rx_valid  out  1  one-cycle pulse when rx_data is updated.
- tx_data  in  8  byte to return on a read; sampled at load points.
- tx_req  out  1  one-cycle pulse when tx_data has just been latched.
- busy  out  1  high from address match until STOP or non-matching START.
- addr_hit  out  1  one-cycle pulse on address match.

Behaviour:
- Reset (sync, dominates everything): state=IDLE, sda released ('z'), rx_data=0, rx_valid=0, tx_req=0, busy=0, addr_hit=0, bit counter=0, shift reg=0.
- Reset mid-transfer: release sda on the next edge and ignore the bus until the next START.
- Input conditioning: `scl`/`sda` pass through SYNC_STAGES flops. Edges are detected from the last two synced samples.
- START = synced sda 1->0 while synced scl=1.
- STOP = synced sda 0->1 while synced scl=1.
- START or STOP is recognised in any state and takes precedence over bit sampling in the same cycle.
- START (including repeated START): go to ADDR, clear bit counter, release sda.
- STOP: go to IDLE, release sda, busy=0.
- Bits are sampled on the scl rising edge. sda is changed only on the scl falling edge (plus one CLOCK_50 cycle).
- Bits are MSB first.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits (7 address + R/W). After the 8th rising edge:
    - match with SLAVE_ADDR -> ADDR_ACK, latch rw, busy=1, pulse addr_hit;
    - mismatch -> IDLE, sda never driven.
  - ADDR_ACK: on the next scl falling edge drive sda=0. On the following falling edge:
    - if rw=0: release sda, go to WRITE;
    - if rw=1: latch tx_data, pulse tx_req, drive bit7, go to READ.
  - WRITE: shift 8 bits. On the 8th rising edge, load rx_data and pulse rx_valid (same cycle). Go to WRITE_ACK.
  - WRITE_ACK: drive sda=0 for one SCL low/high period (from falling edge to falling edge), then release and return to WRITE.
  - READ: drive sda=0 for a 0 bit, release for a 1 bit. Update on each falling edge. After the 8th bit's falling edge release sda and go to READ_ACK.
  - READ_ACK: sample master ACK on the rising edge.
    - sda=0 (ACK): on the falling edge latch tx_data, pulse tx_req, drive bit7, go to READ.
    - sda=1 (NACK): stay released and go to IDLE_WAIT until STOP/START.
- Bit counter is 3 bits, wraps 7->0 at byte boundary.
- busy: asserted the cycle after address match; deasserted on STOP, on mismatch after a repeated START, or on reset.
- No clock stretching; the master's scl is trusted.

Optional Feature:
- Macro: I2C_SLAVE_GLITCH_FILTER_EN.
- Defined: after the synchronisers, each of scl/sda feeds a 3-sample majority/stability filter. The filtered value changes only after 3 consecutive equal synced samples, which suppresses spikes of 2 cycles or fewer (≤40 ns). Adds 2 cycles of input latency.
- Undefined: synced values are used directly.
- Protocol behaviour is identical in both builds.

Test Plan:
- Write 0x42/W, data 0xA5, STOP -> ACK (sda=0) on both 9th clocks; rx_data=0xA5 with a single rx_valid pulse; busy 1 then 0 after STOP.
- Address 0x43/W -> no ACK (sda stays 'z' on 9th clock); addr_hit never pulses; busy stays 0; state returns to IDLE.
- Read 0x42/R, tx_data=0x3C, master ACK, tx_data=0xF0, master NACK, STOP -> bus bytes 0x3C then 0xF0; two tx_req pulses; sda released after NACK.
- Write 0x42/W 0x11, repeated START, 0x42/R with tx_data=0x99 -> rx_data=0x11; read returns 0x99; busy stays 1 across the repeated START.
- Assert reset while the block drives ACK low -> sda released within 1 cycle; outputs reach reset values; the next full write of 0x5A is received correctly.
- With I2C_SLAVE_GLITCH_FILTER_EN defined, inject a 2-cycle low pulse on scl during a data bit -> no extra bit counted; received byte is unchanged (0xA5).
